// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweeper: op codes, FSM encoding and the
// truth-table length helper.
package gate_sweep_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_BUF  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of distinct input vectors for an n_in-input gate.
  function automatic int unsigned table_len(input int unsigned n_in);
    return 32'(1) << n_in;
  endfunction

endpackage

// File: rtl/nin_gate.sv
// N-input combinational gate with a 3-bit run-time operation select.
module nin_gate
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 2
) (
  input  logic [N_IN-1:0] in,
  input  logic [2:0]      op,
  output logic            out
);

  // Reduction operators collapse to BUF/NOT naturally when N_IN is 1.
  always_comb begin
    out = 1'b0;
    case (op)
      OP_AND:  out = &in;
      OP_OR:   out = |in;
      OP_XOR:  out = ^in;
      OP_NAND: out = ~&in;
      OP_NOR:  out = ~|in;
      OP_XNOR: out = ~^in;
      OP_BUF:  out = in[0];
      default: out = ~in[0];
    endcase
  end

endmodule

// File: rtl/gate_sweep.sv
// Sequencer that sweeps every input vector through an nin_gate, holding each
// for HOLD cycles, and records the resulting truth table.
module gate_sweep
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 2,
  parameter int unsigned HOLD = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op,
  output logic [N_IN-1:0]        vec_out,
  output logic                   gate_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   table_valid
);

  localparam int unsigned TLEN = table_len(N_IN);
  localparam int unsigned HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  state_t            state_q, state_n;
  logic [N_IN-1:0]   vec_n;
  logic [2:0]        op_q, op_n;
  logic [HW-1:0]     hold_q, hold_n;
  logic [TLEN-1:0]   table_n;
  logic              valid_n;
  logic              busy_n;
  logic              done_n;

  nin_gate #(.N_IN(N_IN)) u_gate (
    .in  (vec_out),
    .op  (op_q),
    .out (gate_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_out     <= '0;
      op_q        <= OP_AND;
      hold_q      <= '0;
      table_out   <= '0;
      table_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      vec_out     <= vec_n;
      op_q        <= op_n;
      hold_q      <= hold_n;
      table_out   <= table_n;
      table_valid <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Terminal vector is checked before incrementing so vec_out never wraps.
  always_comb begin
    state_n = state_q;
    vec_n   = vec_out;
    op_n    = op_q;
    hold_n  = hold_q;
    table_n = table_out;
    valid_n = table_valid;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_n    = op;
          table_n = '0;
          valid_n = 1'b0;
          vec_n   = '0;
          hold_n  = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (hold_q == HOLD_LAST) begin
          table_n[vec_out] = gate_out;
          hold_n = '0;
          if (vec_out == VEC_LAST) begin
            valid_n = 1'b1;
            state_n = ST_DONE;
          end else begin
            vec_n = vec_out + N_IN'(1);
          end
        end else begin
          hold_n = hold_q + HW'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n == ST_RUN);
    done_n = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_gate_sweep.sv
// Directed bench for gate_sweep across four parameter sets with hand-computed
// truth tables and sweep lengths.
module tb_gate_sweep;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a   [4];
  logic       start_a [4];
  logic [2:0] op_a    [4];

  logic [1:0] v0; logic g0, b0, d0, tv0; logic [3:0] t0;
  logic [2:0] v1; logic g1, b1, d1, tv1; logic [7:0] t1;
  logic [1:0] v2; logic g2, b2, d2, tv2; logic [3:0] t2;
  logic [0:0] v3; logic g3, b3, d3, tv3; logic [1:0] t3;

  logic [2:0] vec_a   [4];
  logic [7:0] tbl_a   [4];
  logic       gate_a  [4];
  logic       busy_a  [4];
  logic       done_a  [4];
  logic       valid_a [4];

  gate_sweep #(.N_IN(2), .HOLD(2)) u0 (
    .clk(clk), .rst(rst_a[0]), .start(start_a[0]), .op(op_a[0]),
    .vec_out(v0), .gate_out(g0), .busy(b0), .done(d0),
    .table_out(t0), .table_valid(tv0));
  gate_sweep #(.N_IN(3), .HOLD(1)) u1 (
    .clk(clk), .rst(rst_a[1]), .start(start_a[1]), .op(op_a[1]),
    .vec_out(v1), .gate_out(g1), .busy(b1), .done(d1),
    .table_out(t1), .table_valid(tv1));
  gate_sweep #(.N_IN(2), .HOLD(3)) u2 (
    .clk(clk), .rst(rst_a[2]), .start(start_a[2]), .op(op_a[2]),
    .vec_out(v2), .gate_out(g2), .busy(b2), .done(d2),
    .table_out(t2), .table_valid(tv2));
  gate_sweep #(.N_IN(1), .HOLD(2)) u3 (
    .clk(clk), .rst(rst_a[3]), .start(start_a[3]), .op(op_a[3]),
    .vec_out(v3), .gate_out(g3), .busy(b3), .done(d3),
    .table_out(t3), .table_valid(tv3));

  assign vec_a[0] = 3'(v0);  assign tbl_a[0] = 8'(t0);
  assign vec_a[1] = v1;      assign tbl_a[1] = t1;
  assign vec_a[2] = 3'(v2);  assign tbl_a[2] = 8'(t2);
  assign vec_a[3] = 3'(v3);  assign tbl_a[3] = 8'(t3);
  assign gate_a[0] = g0;  assign busy_a[0] = b0;  assign done_a[0] = d0;  assign valid_a[0] = tv0;
  assign gate_a[1] = g1;  assign busy_a[1] = b1;  assign done_a[1] = d1;  assign valid_a[1] = tv1;
  assign gate_a[2] = g2;  assign busy_a[2] = b2;  assign done_a[2] = d2;  assign valid_a[2] = tv2;
  assign gate_a[3] = g3;  assign busy_a[3] = b3;  assign done_a[3] = d3;  assign valid_a[3] = tv3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start from IDLE, then follow the sweep until busy drops (bounded).
  task automatic run_sweep(input int s, input logic [2:0] o, input int hold,
                           input int len, input logic [7:0] exp_tbl,
                           input logic disturb, input string tag);
    int n;
    start_a[s] = 1'b1;
    op_a[s]    = o;
    tick();
    start_a[s] = 1'b0;
    check({tag, "_acc_busy"},  32'(busy_a[s]), 1);
    check({tag, "_acc_valid"}, 32'(valid_a[s]), 0);
    check({tag, "_acc_table"}, 32'(tbl_a[s]), 0);
    n = 0;
    while (busy_a[s] && n < 64) begin
      check({tag, "_vec_seq"}, 32'(vec_a[s]), 32'(n / hold));
      check({tag, "_gate"}, 32'(gate_a[s]), 32'(exp_tbl[vec_a[s]]));
      n++;
      if (disturb && n == 3) begin
        op_a[s]    = OP_OR;
        start_a[s] = 1'b1;
      end else begin
        start_a[s] = 1'b0;
      end
      tick();
    end
    start_a[s] = 1'b0;
    check({tag, "_len"},   32'(n), 32'(len));
    check({tag, "_done"},  32'(done_a[s]), 1);
    check({tag, "_busy"},  32'(busy_a[s]), 0);
    check({tag, "_valid"}, 32'(valid_a[s]), 1);
    check({tag, "_table"}, 32'(tbl_a[s]), 32'(exp_tbl));
    check({tag, "_vlast"}, 32'(vec_a[s]), 32'(len / hold - 1));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_a[i] = 1'b1; start_a[i] = 1'b0; op_a[i] = OP_XNOR;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_busy",  32'(busy_a[i]), 0);
      check("rst_done",  32'(done_a[i]), 0);
      check("rst_vec",   32'(vec_a[i]), 0);
      check("rst_table", 32'(tbl_a[i]), 0);
      check("rst_valid", 32'(valid_a[i]), 0);
    end
    // op_q resets to AND: vector 0 gives 0 on every instance.
    check("rst_gate0", 32'(gate_a[0]), 0);

    // N_IN=2 HOLD=2: OR, then AND and XOR back-to-back.
    run_sweep(0, OP_OR, 2, 8, 8'h0E, 1'b0, "or");
    tick();
    check("or_idle_done",  32'(done_a[0]), 0);
    check("or_idle_valid", 32'(valid_a[0]), 1);
    check("or_idle_table", 32'(tbl_a[0]), 32'h0E);
    run_sweep(0, OP_AND, 2, 8, 8'h08, 1'b0, "and");
    tick();
    run_sweep(0, OP_XOR, 2, 8, 8'h06, 1'b0, "xor");

    // N_IN=3 HOLD=1: NAND with op/start disturbed mid-run.
    run_sweep(1, OP_NAND, 1, 8, 8'h7F, 1'b1, "nand");
    tick();
    check("nand_no_restart", 32'(busy_a[1]), 0);

    // N_IN=2 HOLD=3: NOR interrupted by reset in busy cycle 5.
    start_a[2] = 1'b1;
    op_a[2]    = OP_NOR;
    tick();
    start_a[2] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("nor_part_busy",  32'(busy_a[2]), 1);
    check("nor_part_vec",   32'(vec_a[2]), 1);
    check("nor_part_table", 32'(tbl_a[2]), 32'h1);
    rst_a[2] = 1'b1;
    tick();
    rst_a[2] = 1'b0;
    check("nor_rst_busy",  32'(busy_a[2]), 0);
    check("nor_rst_vec",   32'(vec_a[2]), 0);
    check("nor_rst_table", 32'(tbl_a[2]), 0);
    check("nor_rst_valid", 32'(valid_a[2]), 0);
    for (int i = 0; i < 14; i++) begin
      check("nor_rst_nodone", 32'(done_a[2]), 0);
      tick();
    end
    run_sweep(2, OP_NOR, 3, 12, 8'h01, 1'b0, "nor");

    // N_IN=1 HOLD=2: NOT, start in DONE ignored, next IDLE start accepted.
    run_sweep(3, OP_NOT, 2, 4, 8'h01, 1'b0, "not");
    start_a[3] = 1'b1;
    op_a[3]    = OP_AND;
    tick();
    start_a[3] = 1'b0;
    check("not_ign_busy",  32'(busy_a[3]), 0);
    check("not_ign_done",  32'(done_a[3]), 0);
    check("not_ign_valid", 32'(valid_a[3]), 1);
    check("not_ign_table", 32'(tbl_a[3]), 32'h1);
    run_sweep(3, OP_AND, 2, 4, 8'h02, 1'b0, "buf1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sweep.md
Name: gate_sweep

Overview:
Parametrised successor to the two-input OR exercise. Contains an N_IN-input logic gate with run-time operation select and drives a built-in sequencer. The sequencer steps through all 2^N_IN input vectors, holding each for HOLD cycles. It captures the complete truth table into a register so a bench or a display block can read it out once the sweep is done.

Parameters:
N_IN, 2, number of gate inputs (legal 1..6)
HOLD, 2, cycles each input vector is held (legal >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; sampled only in IDLE
op  input  3  gate operation; sampled together with start
vec_out  output  N_IN  current input vector applied to the gate
gate_out  output  1  gate result for vec_out under the latched op (combinational from vec_out and op_q)
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse in the cycle after the last capture
table_out  output  2^N_IN  captured truth table; bit i = gate result for vector i
table_valid  output  1  high from done until the next accepted start or reset

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE
  - vec_out=0, op_q=0 (AND), busy=0, done=0
  - table_out=0, table_valid=0
  - hold counter=0
  - Reset overrides every other input, including mid-sweep; a partial table is discarded.
- op encoding:
  - 0 AND, 1 OR, 2 XOR (odd parity), 3 NAND, 4 NOR, 5 XNOR
  - 6 BUF (vec_out[0]), 7 NOT (~vec_out[0])
  - Every code is legal.
  - With N_IN=1, AND/OR/XOR reduce to BUF, and NAND/NOR/XNOR reduce to NOT.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - busy=0.
    - If start=1: latch op into op_q, clear table_out, clear table_valid, set vec_out=0, set hold counter=0, go to RUN.
    - Latency: start sampled at edge t, so busy=1 and vec_out=0 are visible after edge t.
  - RUN:
    - busy=1. The hold counter increments each cycle.
    - When hold counter == HOLD-1: write table_out[vec_out] <= gate_out and reset the hold counter.
    - If vec_out == 2^N_IN-1, go to DONE; otherwise vec_out increments by 1.
    - No wrap into a second pass.
    - start is ignored in RUN. op changes in RUN have no effect; op_q is used.
  - DONE:
    - Lasts exactly one cycle: done=1, busy=0, table_valid=1.
    - vec_out holds the last vector (2^N_IN-1).
    - Then go to IDLE. start in the DONE cycle is ignored.
- Timing:
  - Sweep length is 2^N_IN*HOLD cycles of busy=1.
  - With start accepted at edge t, done is high in the cycle after edge t+2^N_IN*HOLD.
- HOLD=1: a new vector is applied every cycle, and each capture occurs in the vector's only cycle.
- Back-to-back: start may be accepted on the first IDLE cycle after DONE. table_valid then drops and table_out clears on that edge.
- Hold counter width is clog2(HOLD) (minimum 1). vec_out counter width is N_IN with no overflow: the terminal compare precedes the increment.

Decomposition:
- Package gate_sweep_pkg:
  - op code localparams (OP_AND..OP_NOT)
  - FSM state encoding (2-bit enum IDLE/RUN/DONE)
  - function computing table length 2^N_IN
- Sub-module nin_gate: purely combinational.
  - Parameters: N_IN.
  - Ports: in[N_IN-1:0], op[2:0], out.
  - Instantiated once and reusable elsewhere in the course material.
- The sequencer FSM and the table register stay in gate_sweep.

Test Plan:
1. N_IN=2, HOLD=2, op=1 (OR), start pulse.
   - vec_out 0,0,1,1,2,2,3,3 over 8 busy cycles.
   - done 1 cycle later; table_out=4'b1110, table_valid=1.
2. Same setup, op=0 then op=2 sweeps back-to-back.
   - AND table=4'b1000, XOR table=4'b0110.
   - table_valid falls on the second start edge; table_out=0 during the second run.
3. N_IN=3, HOLD=1, op=3 (NAND).
   - Busy for 8 cycles, table_out=8'b0111_1111.
   - op changed to OR and start pulsed mid-run: no effect.
4. N_IN=2, HOLD=3, op=4 (NOR); assert rst at busy cycle 5.
   - Next cycle: busy=0, vec_out=0, table_out=0, table_valid=0, no done.
   - A fresh start then completes with table_out=4'b0001.
5. N_IN=1, HOLD=2, op=7 (NOT).
   - table_out=2'b01, sweep length 4 cycles.
   - start asserted in the DONE cycle is ignored; the next IDLE-cycle start is accepted.
